lu_arbiter: RTL



---
 rtl/lu_pkg.sv | 17 +
 rtl/lu16_core.sv | 27 ++
 rtl/lu_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/lu_pkg.sv
// Shared definitions for the shared 16-bit logic unit and its arbiter.
package lu_pkg;

   localparam int LU_W = 16;

   typedef logic [LU_W-1:0] lu_word_t;

   localparam logic [2:0] LU_AND  = 3'b000;
   localparam logic [2:0] LU_OR   = 3'b001;
   localparam logic [2:0] LU_NAND = 3'b010;
   localparam logic [2:0] LU_NOR  = 3'b011;
   localparam logic [2:0] LU_NOT  = 3'b100;
   localparam logic [2:0] LU_XOR  = 3'b101;
   localparam logic [2:0] LU_XNOR = 3'b110;
   localparam logic [2:0] LU_NEG  = 3'b111;

endpackage

// File: rtl/lu16_core.sv
// Purely combinational 16-bit logic unit: eight bitwise/negate operations.
module lu16_core
   import lu_pkg::*;
(
   input  logic [2:0]      op,
   input  logic [LU_W-1:0] a,
   input  logic [LU_W-1:0] b,
   output logic [LU_W-1:0] res
);

   // opcode decode
   always_comb begin
      res = {LU_W{1'b0}};
      case (op)
         LU_AND:  res = a & b;
         LU_OR:   res = a | b;
         LU_NAND: res = ~(a & b);
         LU_NOR:  res = ~(a | b);
         LU_NOT:  res = ~a;
         LU_XOR:  res = a ^ b;
         LU_XNOR: res = ~(a ^ b);
         LU_NEG:  res = ~a + 16'd1;
         default: res = {LU_W{1'b0}};
      endcase
   end

endmodule

// File: rtl/lu_arbiter.sv
// Two-requester round-robin arbiter sharing one lu16_core, with a registered,
// tagged valid/ready result channel and a delivered-result counter.
module lu_arbiter
   import lu_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [2:0]      req_op0,
   input  logic [2:0]      req_op1,
   input  logic [LU_W-1:0] req_a0,
   input  logic [LU_W-1:0] req_a1,
   input  logic [LU_W-1:0] req_b0,
   input  logic [LU_W-1:0] req_b1,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [LU_W-1:0] res_data,
   output logic            res_tag,
   output logic            res_zero,
   output logic [15:0]     op_count
);

   logic            prio_q, prio_d;
   logic            res_valid_q, res_valid_d;
   logic [LU_W-1:0] res_data_q, res_data_d;
   logic            res_tag_q, res_tag_d;
   logic            res_zero_q, res_zero_d;
   logic [15:0]     op_count_q, op_count_d;

   logic [1:0]      grant_s;
   logic            slot_free_s;
   logic            accept_s;
   logic            deliver_s;
   logic [2:0]      sel_op_s;
   logic [LU_W-1:0] sel_a_s, sel_b_s, lu_res_s;

   assign slot_free_s = ~res_valid_q | res_ready;
   assign deliver_s   = res_valid_q & res_ready;
   assign accept_s    = |grant_s;

   // grant depends only on handshake state, never on operands; held off during reset
   always_comb begin
      grant_s = 2'b00;
      if (!reset && slot_free_s) begin
         case (req_valid)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = prio_q ? 2'b10 : 2'b01;
            default: grant_s = 2'b00;
         endcase
      end else begin
         grant_s = 2'b00;
      end
   end

   assign req_ready = grant_s;

   // operand mux in front of the single shared logic unit
   always_comb begin
      if (grant_s[1]) begin
         sel_op_s = req_op1;
         sel_a_s  = req_a1;
         sel_b_s  = req_b1;
      end else begin
         sel_op_s = req_op0;
         sel_a_s  = req_a0;
         sel_b_s  = req_b0;
      end
   end

   lu16_core u_core (
      .op  (sel_op_s),
      .a   (sel_a_s),
      .b   (sel_b_s),
      .res (lu_res_s)
   );

   // next-state for pointer, result register and counter
   always_comb begin
      prio_d      = prio_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_tag_d   = res_tag_q;
      res_zero_d  = res_zero_q;
      op_count_d  = deliver_s ? (op_count_q + 16'd1) : op_count_q;
      if (accept_s) begin
         // prio becomes ~i for granted requester i, which equals grant_s[0]
         prio_d      = grant_s[0];
         res_valid_d = 1'b1;
         res_data_d  = lu_res_s;
         res_tag_d   = grant_s[1];
         res_zero_d  = (lu_res_s == 16'h0000);
      end else if (deliver_s) begin
         res_valid_d = 1'b0;
      end else begin
         res_valid_d = res_valid_q;
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= 16'h0000;
         res_tag_q   <= 1'b0;
         res_zero_q  <= 1'b0;
         op_count_q  <= 16'h0000;
      end else begin
         prio_q      <= prio_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_tag_q   <= res_tag_d;
         res_zero_q  <= res_zero_d;
         op_count_q  <= op_count_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_tag   = res_tag_q;
   assign res_zero  = res_zero_q;
   assign op_count  = op_count_q;

endmodule
